// File: rtl/control_unit_if.sv
// Signal bundle between the microcontroller datapath (master) and its control unit (slave).
interface control_unit_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [5:0]       Opcode;
  logic             z;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             s_skip;
  logic [2:0]       Op;
  logic             zflag;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output Opcode, z,
    input  s_inc, s_inm, we3, s_skip, Op, zflag, halted, illegal, instr_count
  );

  modport slave (
    input  Opcode, z,
    output s_inc, s_inm, we3, s_skip, Op, zflag, halted, illegal, instr_count
  );
endinterface

// File: rtl/control_unit.sv
// Opcode decoder for the single-cycle microcontroller, with a registered zero flag,
// RUN/HALT state, sticky illegal-opcode flag and saturating retired-instruction counter.
module control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.slave  bus
);

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic             zflag_q, zflag_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_alu, is_li, is_ctl, is_halt, is_illegal;
  logic s_inc, s_inm, we3, s_skip;
  logic [2:0] op;

  // Opcode[1:0] overlaps a register field for ALU and LI, so only [5:2] is decoded there.
  always_comb begin
    is_alu     = bus.Opcode[5];
    is_li      = (bus.Opcode[5:2] == 4'b0000);
    is_ctl     = (bus.Opcode[5:4] == 2'b01) && (bus.Opcode[3:0] <= 4'b0101);
    is_halt    = (bus.Opcode == 6'b011111);
    is_illegal = !is_alu && !is_li && !is_ctl && !is_halt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      zflag_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      zflag_q   <= zflag_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // All architectural state is frozen outside RUN; HALT itself retires on entry.
  always_comb begin
    state_d   = state_q;
    zflag_d   = zflag_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (state_q == RUN) begin
      if (is_halt)    state_d   = HALT;
      if (is_alu)     zflag_d   = bus.z;
      if (is_illegal) illegal_d = 1'b1;
      if (cnt_q != '1) cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    s_skip = 1'b0;
    op     = 3'b000;
    if (reset) begin
      s_inc = 1'b1;
    end else if (state_q == HALT) begin
      s_inc = 1'b0;
    end else if (is_alu) begin
      op  = bus.Opcode[4:2];
      we3 = 1'b1;
    end else if (is_li) begin
      we3   = 1'b1;
      s_inm = 1'b1;
    end else begin
      case (bus.Opcode)
        6'b010000: s_inc  = 1'b0;
        6'b010001: s_inc  = ~zflag_q;
        6'b010010: s_inc  = zflag_q;
        6'b010011: s_skip = zflag_q;
        6'b010100: s_skip = ~zflag_q;
        6'b011111: s_inc  = 1'b0;
        default:   s_inc  = 1'b1;
      endcase
    end
  end

  assign bus.s_inc       = s_inc;
  assign bus.s_inm       = s_inm;
  assign bus.we3         = we3;
  assign bus.s_skip      = s_skip;
  assign bus.Op          = op;
  assign bus.zflag       = zflag_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expectations queued as stimulus is applied, popped on sampling.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst, rst4;
  always #5 clk = ~clk;

  control_unit_if #(.CNT_W(16)) bus ();
  control_unit_if #(.CNT_W(4))  bus4 ();

  control_unit #(.CNT_W(16)) dut  (.clk(clk), .reset(rst),  .bus(bus));
  control_unit #(.CNT_W(4))  dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Decode outputs packed as {s_inc, s_inm, we3, s_skip, Op}.
  function automatic logic [31:0] D(input logic si, input logic sm, input logic we,
                                    input logic sk, input logic [2:0] o);
    return {25'd0, si, sm, we, sk, o};
  endfunction

  function automatic logic [31:0] dec();
    return {25'd0, bus.s_inc, bus.s_inm, bus.we3, bus.s_skip, bus.Op};
  endfunction

  task automatic drive(input logic [5:0] op, input logic zv, input logic r);
    @(negedge clk);
    bus.Opcode = op;
    bus.z      = zv;
    rst        = r;
    #1;
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] e);
    want(tag, e);
    got(dec());
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] obs, input logic [31:0] e);
    want(tag, e);
    got(obs);
  endtask

  initial begin
    rst = 1'b1;
    rst4 = 1'b1;
    bus.Opcode = 6'b100100;
    bus.z = 1'b1;
    bus4.Opcode = 6'b010101;
    bus4.z = 1'b0;

    // Reset held for two edges
    drive(6'b100100, 1'b1, 1'b1);
    chk_dec("rst_dec0", D(1, 0, 0, 0, 3'b000));
    drive(6'b100100, 1'b1, 1'b1);
    chk_dec("rst_dec1", D(1, 0, 0, 0, 3'b000));
    chk_reg("rst_zflag",   32'(bus.zflag),       0);
    chk_reg("rst_count",   32'(bus.instr_count), 0);
    chk_reg("rst_halted",  32'(bus.halted),      0);
    chk_reg("rst_illegal", 32'(bus.illegal),     0);

    // Release: ALU Op=001, z=0 so the later LI/ALU pair shows the flag moving
    drive(6'b100100, 1'b0, 1'b0);
    chk_dec("alu001_dec", D(1, 0, 1, 0, 3'b001));
    drive(6'b000000, 1'b1, 1'b0);
    chk_reg("alu001_zflag", 32'(bus.zflag), 0);
    chk_reg("cnt1", 32'(bus.instr_count), 1);
    chk_dec("li_dec", D(1, 1, 1, 0, 3'b000));
    drive(6'b101000, 1'b1, 1'b0);
    chk_reg("li_zflag_hold", 32'(bus.zflag), 0);
    chk_dec("alu010_dec", D(1, 0, 1, 0, 3'b010));

    // Flow control with zflag=1
    drive(6'b010001, 1'b0, 1'b0);
    chk_reg("alu010_zflag", 32'(bus.zflag), 1);
    chk_reg("cnt3", 32'(bus.instr_count), 3);
    chk_dec("jz_z1",   D(0, 0, 0, 0, 3'b000));
    drive(6'b010010, 1'b0, 1'b0);
    chk_dec("jnz_z1",  D(1, 0, 0, 0, 3'b000));
    drive(6'b010011, 1'b0, 1'b0);
    chk_dec("skz_z1",  D(1, 0, 0, 1, 3'b000));
    drive(6'b010100, 1'b0, 1'b0);
    chk_dec("sknz_z1", D(1, 0, 0, 0, 3'b000));
    chk_reg("flow_zflag_hold", 32'(bus.zflag), 1);

    // ALU with z=0, then flow control with zflag=0
    drive(6'b100000, 1'b0, 1'b0);
    chk_dec("alu000_dec", D(1, 0, 1, 0, 3'b000));
    drive(6'b010001, 1'b1, 1'b0);
    chk_reg("alu000_zflag", 32'(bus.zflag), 0);
    chk_dec("jz_z0",   D(1, 0, 0, 0, 3'b000));
    drive(6'b010010, 1'b1, 1'b0);
    chk_dec("jnz_z0",  D(0, 0, 0, 0, 3'b000));
    drive(6'b010011, 1'b1, 1'b0);
    chk_dec("skz_z0",  D(1, 0, 0, 0, 3'b000));
    drive(6'b010100, 1'b1, 1'b0);
    chk_dec("sknz_z0", D(1, 0, 0, 1, 3'b000));
    drive(6'b010000, 1'b1, 1'b0);
    chk_dec("j_dec",   D(0, 0, 0, 0, 3'b000));
    chk_reg("cnt12", 32'(bus.instr_count), 12);

    // Illegal opcode: sticky across legal instructions, zflag untouched
    drive(6'b001010, 1'b1, 1'b0);
    chk_dec("illegal_dec", D(1, 0, 0, 0, 3'b000));
    chk_reg("illegal_pre", 32'(bus.illegal), 0);
    for (int i = 0; i < 5; i++) begin
      drive((i == 2) ? 6'b000011 : 6'b010101, 1'b1, 1'b0);
      chk_reg("illegal_sticky", 32'(bus.illegal), 1);
      chk_reg("illegal_zflag",  32'(bus.zflag),   0);
      chk_reg("illegal_cnt",    32'(bus.instr_count), 32'(14 + i));
    end

    // Reset mid-run, then three instructions and HALT
    drive(6'b010101, 1'b1, 1'b1);
    drive(6'b010101, 1'b0, 1'b0);
    chk_reg("rst2_cnt",     32'(bus.instr_count), 0);
    chk_reg("rst2_illegal", 32'(bus.illegal),     0);
    drive(6'b000000, 1'b0, 1'b0);
    drive(6'b100100, 1'b1, 1'b0);
    drive(6'b011111, 1'b0, 1'b0);
    chk_dec("halt_dec", D(0, 0, 0, 0, 3'b000));
    chk_reg("prehalt_cnt",    32'(bus.instr_count), 3);
    chk_reg("prehalt_halted", 32'(bus.halted),      0);
    chk_reg("prehalt_zflag",  32'(bus.zflag),       1);
    drive(6'b111100, 1'b0, 1'b0);
    chk_reg("halted_1",    32'(bus.halted),      1);
    chk_reg("halted_cnt",  32'(bus.instr_count), 4);
    chk_dec("halted_alu_dec", D(0, 0, 0, 0, 3'b000));
    drive(6'b001010, 1'b0, 1'b0);
    chk_reg("halted_zflag",   32'(bus.zflag),       1);
    chk_reg("halted_cnt_frz", 32'(bus.instr_count), 4);
    chk_dec("halted_ill_dec", D(0, 0, 0, 0, 3'b000));
    drive(6'b010101, 1'b0, 1'b1);
    chk_reg("halted_illegal_frz", 32'(bus.illegal), 0);
    chk_reg("halted_cnt_frz2",    32'(bus.instr_count), 4);
    chk_dec("halt_rst_dec", D(1, 0, 0, 0, 3'b000));
    drive(6'b010101, 1'b0, 1'b0);
    chk_reg("unhalt_halted", 32'(bus.halted),      0);
    chk_reg("unhalt_cnt",    32'(bus.instr_count), 0);
    chk_reg("unhalt_zflag",  32'(bus.zflag),       0);
    chk_dec("unhalt_nop_dec", D(1, 0, 0, 0, 3'b000));

    // Saturation of a 4-bit counter over 20 NOPs
    @(negedge clk);
    rst4 = 1'b0;
    bus4.Opcode = 6'b010101;
    #1;
    chk_reg("sat_cnt0", 32'(bus4.instr_count), 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      chk_reg("sat_cnt", 32'(bus4.instr_count), (i > 15) ? 32'd15 : 32'(i));
    end

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
